// File: rtl/rf_wb_arbiter.sv
// Register-file write-port controller: round-robin arbitration of ALU / load / mult-div
// writebacks onto one registered write port, plus a per-register pending-write scoreboard.
module rf_wb_arbiter #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          alu_valid,
    input  logic [AW-1:0] alu_addr,
    input  logic [DW-1:0] alu_data,
    output logic          alu_ready,
    input  logic          ld_valid,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_data,
    output logic          ld_ready,
    input  logic          md_valid,
    input  logic [AW-1:0] md_addr,
    input  logic [DW-1:0] md_data,
    output logic          md_ready,
    input  logic          iss_valid,
    input  logic [AW-1:0] iss_addr,
    input  logic [AW-1:0] chk_addr1,
    input  logic [AW-1:0] chk_addr2,
    output logic          chk_busy1,
    output logic          chk_busy2,
    output logic          rf_we,
    output logic [AW-1:0] rf_waddr,
    output logic [DW-1:0] rf_wdata,
    output logic          sb_err
);
    localparam int NREG = 1 << AW;

    // Handshake: a source transfers in the cycle where its valid and ready are both high;
    // ready is asserted only for the single valid source chosen by the round-robin pointer.
    logic [1:0]    ptr;
    logic [2:0]    valid_vec;
    logic [2:0]    gnt;
    logic [1:0]    win;
    logic          xfer;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;
    logic          wb_en;
    logic          iss_en;
    logic [1:0]    cnt [NREG];

    assign valid_vec = {md_valid, ld_valid, alu_valid};

    always_comb begin
        gnt = '0;
        win = 2'd0;
        for (int k = 0; k < 3; k++) begin
            if (gnt == 3'b000 && valid_vec[(int'(ptr) + k) % 3]) begin
                gnt[(int'(ptr) + k) % 3] = 1'b1;
                win = 2'((int'(ptr) + k) % 3);
            end
        end
    end

    assign xfer      = |gnt;
    assign alu_ready = gnt[0] & rst_n;
    assign ld_ready  = gnt[1] & rst_n;
    assign md_ready  = gnt[2] & rst_n;

    always_comb begin
        wb_addr = alu_addr;
        wb_data = alu_data;
        case (win)
            2'd1:    begin wb_addr = ld_addr; wb_data = ld_data; end
            2'd2:    begin wb_addr = md_addr; wb_data = md_data; end
            default: begin wb_addr = alu_addr; wb_data = alu_data; end
        endcase
    end

    assign wb_en  = xfer && (wb_addr != '0);
    assign iss_en = iss_valid && (iss_addr != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr      <= 2'd0;
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else begin
            rf_we <= wb_en;
            if (xfer) ptr <= (win == 2'd2) ? 2'd0 : win + 2'd1;
            if (wb_en) begin
                rf_waddr <= wb_addr;
                rf_wdata <= wb_data;
            end
        end
    end

    // Register 0 keeps its reset value forever, so it always reads as not busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) cnt[i] <= 2'd0;
            sb_err <= 1'b0;
        end else begin
            for (int i = 1; i < NREG; i++) begin
                if ((iss_en && iss_addr == AW'(i)) && !(wb_en && wb_addr == AW'(i))) begin
                    if (cnt[i] == 2'd3) sb_err <= 1'b1;
                    else                cnt[i] <= cnt[i] + 2'd1;
                end else if ((wb_en && wb_addr == AW'(i)) && !(iss_en && iss_addr == AW'(i))) begin
                    if (cnt[i] == 2'd0) sb_err <= 1'b1;
                    else                cnt[i] <= cnt[i] - 2'd1;
                end
            end
        end
    end

    assign chk_busy1 = (chk_addr1 != '0) && (cnt[chk_addr1] != 2'd0);
    assign chk_busy2 = (chk_addr2 != '0) && (cnt[chk_addr2] != 2'd0);

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: arbitration order, write-port timing,
// scoreboard busy/saturation/underflow and asynchronous reset.
module tb_rf_wb_arbiter;
    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          alu_valid = 1'b0, ld_valid = 1'b0, md_valid = 1'b0;
    logic [AW-1:0] alu_addr = '0, ld_addr = '0, md_addr = '0;
    logic [DW-1:0] alu_data = '0, ld_data = '0, md_data = '0;
    logic          alu_ready, ld_ready, md_ready;
    logic          iss_valid = 1'b0;
    logic [AW-1:0] iss_addr = '0;
    logic [AW-1:0] chk_addr1 = '0, chk_addr2 = '0;
    logic          chk_busy1, chk_busy2;
    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic          sb_err;

    int errors = 0;
    int checks = 0;

    rf_wb_arbiter #(.DW(DW), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ready(ld_ready),
        .md_valid(md_valid), .md_addr(md_addr), .md_data(md_data), .md_ready(md_ready),
        .iss_valid(iss_valid), .iss_addr(iss_addr),
        .chk_addr1(chk_addr1), .chk_addr2(chk_addr2),
        .chk_busy1(chk_busy1), .chk_busy2(chk_busy2),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .sb_err(sb_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alu_valid = 1'b0; ld_valid = 1'b0; md_valid = 1'b0; iss_valid = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    logic [2:0]    exp_rdy;
    logic [AW-1:0] addr_tab [3];
    logic [DW-1:0] data_tab [3];

    initial begin
        addr_tab[0] = 5'd1; addr_tab[1] = 5'd2; addr_tab[2] = 5'd3;
        data_tab[0] = 32'h1111_0001; data_tab[1] = 32'h2222_0002; data_tab[2] = 32'h3333_0003;

        // Reset values; ready must stay low during reset even with valid high.
        rst_n = 1'b0;
        alu_valid = 1'b1;
        #2;
        check("rst_alu_ready", alu_ready, 0);
        check("rst_rf_we", rf_we, 0);
        check("rst_rf_waddr", rf_waddr, 0);
        check("rst_rf_wdata", rf_wdata, 0);
        check("rst_sb_err", sb_err, 0);
        do_reset();

        // Single ALU writeback to r5 (no prior issue, so underflow is flagged too).
        alu_valid = 1'b1; alu_addr = 5'd5; alu_data = 32'hDEADBEEF;
        #1;
        check("t1_alu_ready", alu_ready, 1);
        check("t1_ld_ready", ld_ready, 0);
        check("t1_md_ready", md_ready, 0);
        step();
        alu_valid = 1'b0;
        check("t1_rf_we", rf_we, 1);
        check("t1_rf_waddr", rf_waddr, 5);
        check("t1_rf_wdata", rf_wdata, 32'hDEADBEEF);
        check("t1_sb_err", sb_err, 1);
        step();
        check("t1_rf_we_off", rf_we, 0);
        check("t1_rf_waddr_hold", rf_waddr, 5);

        // All sources valid continuously: ALU, LD, MD, ALU, ...
        do_reset();
        alu_valid = 1'b1; alu_addr = addr_tab[0]; alu_data = data_tab[0];
        ld_valid  = 1'b1; ld_addr  = addr_tab[1]; ld_data  = data_tab[1];
        md_valid  = 1'b1; md_addr  = addr_tab[2]; md_data  = data_tab[2];
        for (int k = 0; k < 6; k++) begin
            #1;
            exp_rdy = 3'b001 << (k % 3);
            check("rr_ready", {md_ready, ld_ready, alu_ready}, exp_rdy);
            step();
            check("rr_rf_we", rf_we, 1);
            check("rr_rf_waddr", rf_waddr, addr_tab[k % 3]);
            check("rr_rf_wdata", rf_wdata, data_tab[k % 3]);
        end
        idle_inputs();

        // Issue to r7, load writeback to r7 four cycles later.
        do_reset();
        chk_addr1 = 5'd7; chk_addr2 = 5'd0;
        iss_valid = 1'b1; iss_addr = 5'd7;
        #1;
        check("t3_busy_issue_cycle", chk_busy1, 0);
        step();
        iss_valid = 1'b0;
        for (int k = 1; k < 4; k++) begin
            #1;
            check("t3_busy_wait", chk_busy1, 1);
            check("t3_busy2_r0", chk_busy2, 0);
            step();
        end
        ld_valid = 1'b1; ld_addr = 5'd7; ld_data = 32'h0000_0077;
        #1;
        check("t3_ld_ready", ld_ready, 1);
        check("t3_busy_grant", chk_busy1, 1);
        step();
        ld_valid = 1'b0;
        check("t3_busy_cleared", chk_busy1, 0);
        check("t3_rf_we", rf_we, 1);
        check("t3_rf_waddr", rf_waddr, 7);
        check("t3_sb_err", sb_err, 0);

        // Saturation on r4, then three writebacks drain it.
        do_reset();
        chk_addr2 = 5'd4;
        iss_valid = 1'b1; iss_addr = 5'd4;
        step(); step(); step();
        check("t4_sb_err_at3", sb_err, 0);
        check("t4_busy_at3", chk_busy2, 1);
        step();
        iss_valid = 1'b0;
        check("t4_sb_err_sat", sb_err, 1);
        alu_valid = 1'b1; alu_addr = 5'd4; alu_data = 32'h4444;
        step();
        check("t4_busy_wb1", chk_busy2, 1);
        step();
        check("t4_busy_wb2", chk_busy2, 1);
        step();
        alu_valid = 1'b0;
        check("t4_busy_wb3", chk_busy2, 0);
        check("t4_rf_waddr", rf_waddr, 4);

        // Writeback to r0 is consumed silently; writeback to r9 with no issue underflows.
        do_reset();
        chk_addr1 = 5'd9;
        iss_valid = 1'b1; iss_addr = 5'd0;
        md_valid = 1'b1; md_addr = 5'd0; md_data = 32'h5555;
        #1;
        check("t5_md_ready", md_ready, 1);
        step();
        md_valid = 1'b0; iss_valid = 1'b0;
        check("t5_rf_we_r0", rf_we, 0);
        check("t5_rf_waddr_r0", rf_waddr, 0);
        check("t5_sb_err_r0", sb_err, 0);
        alu_valid = 1'b1; alu_addr = 5'd9; alu_data = 32'h9999;
        step();
        alu_valid = 1'b0;
        check("t5_rf_waddr_r9", rf_waddr, 9);
        check("t5_sb_err_r9", sb_err, 1);
        check("t5_busy_r9", chk_busy1, 0);

        // Asynchronous reset in the middle of a burst.
        do_reset();
        chk_addr1 = 5'd10;
        iss_valid = 1'b1; iss_addr = 5'd10;
        alu_valid = 1'b1; alu_addr = addr_tab[0]; alu_data = data_tab[0];
        ld_valid  = 1'b1; ld_addr  = addr_tab[1]; ld_data  = data_tab[1];
        step();
        iss_valid = 1'b0;
        step();
        check("t6_rf_we_pre", rf_we, 1);
        check("t6_busy_pre", chk_busy1, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rf_we_async", rf_we, 0);
        check("t6_rf_waddr_async", rf_waddr, 0);
        check("t6_rf_wdata_async", rf_wdata, 0);
        check("t6_ready_async", {md_ready, ld_ready, alu_ready}, 0);
        idle_inputs();
        step();
        rst_n = 1'b1;
        step();
        check("t6_busy_post", chk_busy1, 0);
        check("t6_sb_err_post", sb_err, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Write-port controller for the three-ported register file. It shares the single register-file write port among three writeback sources: ALU, load unit and mult/div unit. Sources use valid/ready handshakes and are served round-robin. It also keeps a per-register pending-write scoreboard so issue logic can stall on operands whose writeback has not yet landed. It sits between the execution units and the register file and drives the file's write enable, write address and write data.

## Interface
- DW, 32, data width
- AW, 5, register address width (2^AW registers; register 0 hardwired to 0)

- clk  in  1  clock, rising-edge sequential logic
- rst_n  in  1  asynchronous active-low reset
- alu_valid / ld_valid / md_valid  in  1 each  source holds a writeback request
- alu_addr / ld_addr / md_addr  in  AW each  destination register
- alu_data / ld_data / md_data  in  DW each  writeback value
- alu_ready / ld_ready / md_ready  out  1 each  grant; transfer occurs when valid & ready
- iss_valid  in  1  an instruction with a destination register issues this cycle
- iss_addr  in  AW  destination of the issuing instruction
- chk_addr1, chk_addr2  in  AW each  source operands queried by issue logic
- chk_busy1, chk_busy2  out  1 each  queried register has a pending write (combinational)
- rf_we  out  1  to register-file write enable (registered)
- rf_waddr  out  AW  to register-file write address (registered)
- rf_wdata  out  DW  to register-file write data (registered)
- sb_err  out  1  sticky scoreboard overflow/underflow flag

## Operation
- Source indices: ALU=0, LD=1, MD=2. A 2-bit round-robin pointer names the highest-priority source. Reset value is 0.
- Each cycle, the first valid source at or after the pointer (wrapping 2→0) is granted, and only its ready is driven high. ready is combinational from the valid inputs and the pointer. It is never high without the matching valid.
- After a transfer, the pointer moves to winner+1 (mod 3). With no transfer, the pointer holds.
- A source must hold valid, addr and data stable until it is granted. Dropping valid before the grant is illegal.
- Accepted transfer with addr≠0: on the next rising edge, rf_we←1, rf_waddr←addr, rf_wdata←data.
- Accepted transfer with addr=0: the request is consumed, rf_we←0, and the scoreboard is untouched.
- No transfer: rf_we←0. rf_waddr and rf_wdata hold their values.
- Scoreboard: a 2-bit pending counter for each register 1..2^AW−1. Register 0 has no counter and always reads as 0.
  - Issue with iss_addr≠0: the counter for that register increments.
  - Accepted transfer with addr≠0: the counter for that register decrements.
  - Issue and writeback to the same register in the same cycle: the counter is unchanged.
  - Increment at 3: the counter saturates at 3 and sb_err is set.
  - Decrement at 0: the counter stays 0 and sb_err is set.
- chk_busyN = (counter[chk_addrN] ≠ 0). Address 0 always returns 0.
- sb_err is cleared only by reset.

## Timing
- Reset (asynchronous assert, synchronous release on clk rise):
  - rf_we=0, rf_waddr=0, rf_wdata=0
  - all counters 0, pointer 0, sb_err=0
  - all ready outputs 0 while rst_n=0
- Grant in cycle N: rf_we is high in cycle N+1. The register file captures the write on the falling edge inside cycle N+1.
- The counter decrements at the end of cycle N, so busy clears in cycle N+1. A combinational read in cycle N+1 returns the new value after that falling edge, in time for the next rising edge.
- Throughput is one write per cycle. Each source gets at least one grant in any 3 consecutive cycles in which it is valid.
- Busy becomes visible the cycle after iss_valid.
- Reset mid-transfer drops all pending state. Sources must re-present their requests after reset.

## Test plan
- Reset, then ALU valid alone with addr=5, data=0xDEADBEEF → alu_ready=1 in cycle 0; rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF in cycle 1; rf_we=0 in cycle 2.
- All three sources valid continuously with addrs 1/2/3 → grants in order ALU, LD, MD, ALU…; one rf_we per cycle; no source waits more than 2 cycles.
- Issue to r7, then ld writeback to r7 four cycles later → chk_busy1 (chk_addr1=7) is 1 from the cycle after issue through the grant cycle, and 0 in the following cycle.
- Issue to r4 three times, then a fourth time → sb_err=1, counter saturated; three writebacks to r4 then clear busy.
- md writeback to addr 0 → md_ready=1, rf_we stays 0, sb_err stays 0. A writeback to r9 with no prior issue → sb_err=1.
- Assert rst_n=0 mid-burst while rf_we=1 → rf_we, rf_waddr and rf_wdata go to 0 immediately (asynchronously); all busy outputs are 0 after release.
